blade_sequencer: RTL and testbench

Ignition/retraction controller for the lightsaber. It owns the on/off sequencing that the length, color and configuration registers and the power unit follow. It ramps the blade length between 0 and the user target, gates the shared enable, and selects the power-use mode. It also forces a retract and lockout on a power warning.

---
 rtl/lightsaber_pkg.sv | 26 ++
 rtl/blade_sequencer_if.sv | 27 ++
 rtl/blade_sequencer_length_ramp.sv | 40 ++++
 rtl/blade_sequencer.sv | 141 ++++++++++++++
 tb/tb_blade_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lightsaber_pkg.sv
// Shared types and constants for the lightsaber blade control slice.
package lightsaber_pkg;

   localparam int unsigned LEN_W      = 9;
   localparam int unsigned CU_PER_INT = 100;

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_IGNITE   = 3'd1,
      ST_ON       = 3'd2,
      ST_RETRACT  = 3'd3,
      ST_COOLDOWN = 3'd4,
      ST_LOCKOUT  = 3'd5
   } state_t;

   localparam logic [1:0] USE_IDLE  = 2'd0;
   localparam logic [1:0] USE_TRAIN = 2'd1;
   localparam logic [1:0] USE_DUEL  = 2'd2;
   localparam logic [1:0] USE_CUT   = 2'd3;

   // Target length in centi-units from integer and hundredths parts.
   function automatic logic [LEN_W-1:0] target_cu(input logic [1:0] ti, input logic [5:0] td);
      return LEN_W'(ti) * LEN_W'(CU_PER_INT) + LEN_W'(td);
   endfunction

endpackage

// File: rtl/blade_sequencer_if.sv
// User/power-unit side signals of the blade sequencer.
interface blade_sequencer_if;
   import lightsaber_pkg::*;

   logic             on_req;
   logic [1:0]       tgt_int;
   logic [5:0]       tgt_dec;
   logic [1:0]       use_sel;
   logic [7:0]       power_level;
   logic             power_warn;
   logic             blade_on;
   logic [LEN_W-1:0] blade_len;
   logic [1:0]       power_use;
   logic [2:0]       state;
   logic             ignite_denied;
   logic             fault;

   modport master (
      output on_req, tgt_int, tgt_dec, use_sel, power_level, power_warn,
      input  blade_on, blade_len, power_use, state, ignite_denied, fault
   );

   modport slave (
      input  on_req, tgt_int, tgt_dec, use_sel, power_level, power_warn,
      output blade_on, blade_len, power_use, state, ignite_denied, fault
   );
endinterface

// File: rtl/blade_sequencer_length_ramp.sv
// Registered saturating up/down stepper for the blade length.
// Up: min(len+STEP, limit). Down: max(len-STEP, 0, limit).
module length_ramp
   import lightsaber_pkg::*;
#(
   parameter int unsigned STEP = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             dir,
   input  logic [LEN_W-1:0] limit,
   output logic [LEN_W-1:0] len
);

   localparam logic [LEN_W:0] STEP10 = (LEN_W+1)'(STEP);

   logic [LEN_W:0] len10, lim10, up, up_sat, dn, dn_sat, nxt;

   // Next length, computed one bit wider so the step never wraps.
   always_comb begin
      len10  = {1'b0, len};
      lim10  = {1'b0, limit};
      up     = len10 + STEP10;
      up_sat = (up > lim10) ? lim10 : up;
      dn     = (len10 > STEP10) ? len10 - STEP10 : '0;
      dn_sat = (dn < lim10) ? lim10 : dn;
      nxt    = dir ? up_sat : dn_sat;
   end

   // Length register.
   always_ff @(posedge clk) begin
      if (rst || clr)
         len <= '0;
      else if (en)
         len <= LEN_W'(nxt);
   end

endmodule

// File: rtl/blade_sequencer.sv
// Ignition/retraction sequencer: FSM, cooldown counter and fault latch.
module blade_sequencer
   import lightsaber_pkg::*;
#(
   parameter int unsigned STEP       = 10,
   parameter int unsigned MIN_IGNITE = 16,
   parameter int unsigned COOLDOWN   = 8
) (
   input logic          clk,
   input logic          rst,
   blade_sequencer_if.slave bus
);

   localparam int unsigned CW      = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
   localparam logic [CW-1:0] CD_LOAD = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
   localparam logic [LEN_W:0] STEP10 = (LEN_W+1)'(STEP);

   state_t           st, st_n;
   logic             fault, fault_n;
   logic [CW-1:0]    cd, cd_n;
   logic             blade_on_q;
   logic [1:0]       power_use_q;
   logic [LEN_W-1:0] tgt, len;
   logic [LEN_W:0]   tgt10, len10;
   logic             lvl_ok, ign_ok, reach_tgt, reach_zero;
   logic             r_en, r_dir, r_clr;
   logic [LEN_W-1:0] r_lim;

   assign tgt        = target_cu(bus.tgt_int, bus.tgt_dec);
   assign tgt10      = {1'b0, tgt};
   assign len10      = {1'b0, len};
   assign lvl_ok     = bus.power_level >= 8'(MIN_IGNITE);
   assign ign_ok     = bus.on_req && !bus.power_warn && lvl_ok;
   // The ramp's own min/max land exactly on these conditions.
   assign reach_tgt  = (len10 + STEP10) >= tgt10;
   assign reach_zero = len10 <= STEP10;

   length_ramp #(.STEP(STEP)) u_ramp (
      .clk   (clk),
      .rst   (rst),
      .clr   (r_clr),
      .en    (r_en),
      .dir   (r_dir),
      .limit (r_lim),
      .len   (len)
   );

   // Next state, ramp control, cooldown and fault next values.
   always_comb begin
      st_n    = st;
      fault_n = fault;
      cd_n    = cd;
      r_en    = 1'b0;
      r_dir   = 1'b1;
      r_lim   = tgt;
      r_clr   = 1'b0;
      case (st)
         ST_OFF: begin
            if (ign_ok)
               st_n = ST_IGNITE;
         end
         ST_IGNITE, ST_ON: begin
            // Length holds on the exit edge; retract starts next cycle.
            if (bus.power_warn) begin
               st_n    = ST_RETRACT;
               fault_n = 1'b1;
            end else if (!bus.on_req) begin
               st_n = ST_RETRACT;
            end else if (st == ST_IGNITE) begin
               r_en = 1'b1;
               if (reach_tgt)
                  st_n = ST_ON;
            end else begin
               r_en  = 1'b1;
               r_dir = tgt10 > len10;
            end
         end
         ST_RETRACT: begin
            r_en  = 1'b1;
            r_dir = 1'b0;
            r_lim = '0;
            if (reach_zero) begin
               if (fault)
                  st_n = ST_LOCKOUT;
               else if (COOLDOWN == 0)
                  st_n = ST_OFF;
               else begin
                  st_n = ST_COOLDOWN;
                  cd_n = CD_LOAD;
               end
            end
         end
         ST_COOLDOWN: begin
            if (cd == '0)
               st_n = ST_OFF;
            else
               cd_n = cd - 1'b1;
         end
         ST_LOCKOUT: begin
            if (!bus.on_req && !bus.power_warn && lvl_ok) begin
               st_n    = ST_OFF;
               fault_n = 1'b0;
            end
         end
         default: begin
            st_n  = ST_OFF;
            r_clr = 1'b1;
         end
      endcase
   end

   // State, flags and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= ST_OFF;
         fault       <= 1'b0;
         cd          <= '0;
         blade_on_q  <= 1'b0;
         power_use_q <= USE_IDLE;
      end else begin
         st          <= st_n;
         fault       <= fault_n;
         cd          <= cd_n;
         blade_on_q  <= (st_n == ST_IGNITE) || (st_n == ST_ON) || (st_n == ST_RETRACT);
         if (st_n == ST_ON)
            power_use_q <= bus.use_sel;
         else if ((st_n == ST_IGNITE) || (st_n == ST_RETRACT))
            power_use_q <= USE_TRAIN;
         else
            power_use_q <= USE_IDLE;
      end
   end

   assign bus.state         = st;
   assign bus.blade_len     = len;
   assign bus.blade_on      = blade_on_q;
   assign bus.power_use     = power_use_q;
   assign bus.fault         = fault;
   assign bus.ignite_denied = !rst && (st == ST_OFF) && bus.on_req && !ign_ok;

endmodule

// File: tb/tb_blade_sequencer.sv
// Scoreboard bench for blade_sequencer: each queued item carries the inputs
// applied before an edge and the outputs expected just after it.
module tb_blade_sequencer;
   import lightsaber_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   blade_sequencer_if bus ();

   blade_sequencer #(.STEP(10), .MIN_IGNITE(16), .COOLDOWN(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic       rst;
      logic       on;
      logic       warn;
      logic [7:0] lvl;
      logic [1:0] ti;
      logic [5:0] td;
      logic [1:0] us;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [16:0] v;
      string       tag;
   } item_t;

   item_t sb[$];
   stim_t cs;
   int    checks   = 0;
   int    failures = 0;

   function automatic logic [16:0] observed();
      return {bus.state, bus.blade_len, bus.blade_on, bus.power_use, bus.fault, bus.ignite_denied};
   endfunction

   function automatic string fmt(input logic [16:0] v);
      return $sformatf("st=%0d len=%0d on=%0b pu=%0d flt=%0b den=%0b",
                       v[16:14], v[13:5], v[4], v[3:2], v[1], v[0]);
   endfunction

   task automatic push(input state_t st, input int len, input bit on, input int pu,
                       input bit f, input bit den, input string tag);
      item_t it;
      it.s   = cs;
      it.v   = {st, 9'(len), on, 2'(pu), f, den};
      it.tag = tag;
      sb.push_back(it);
   endtask

   task automatic apply(input stim_t s);
      rst             = s.rst;
      bus.on_req      = s.on;
      bus.power_warn  = s.warn;
      bus.power_level = s.lvl;
      bus.tgt_int     = s.ti;
      bus.tgt_dec     = s.td;
      bus.use_sel     = s.us;
   endtask

   task automatic test_reset();
      item_t it;
      cs = '{rst: 1'b1, on: 1'b0, warn: 1'b0, lvl: 8'd200, ti: 2'd1, td: 6'd50, us: 2'd2};
      push(ST_OFF, 0, 0, 0, 0, 0, "reset");
      cs.rst = 1'b0;
      push(ST_OFF, 0, 0, 0, 0, 0, "idle_after_reset");
      while (sb.size() > 0) begin
         it = sb.pop_front();
         apply(it.s);
         @(posedge clk); #1;
         checks++;
         if (observed() !== it.v) begin
            failures++;
            $display("FAIL %s: got %s, want %s", it.tag, fmt(observed()), fmt(it.v));
         end
      end
   endtask

   task automatic test_ignite();
      item_t it;
      cs.on = 1'b1;
      push(ST_IGNITE, 0, 1, 1, 0, 0, "ignite_enter");
      for (int k = 1; k <= 15; k++)
         push((k == 15) ? ST_ON : ST_IGNITE, 10 * k, 1, (k == 15) ? 2 : 1, 0, 0,
              $sformatf("ignite_len_%0d", 10 * k));
      push(ST_ON, 150, 1, 2, 0, 0, "ignite_hold");
      while (sb.size() > 0) begin
         it = sb.pop_front();
         apply(it.s);
         @(posedge clk); #1;
         checks++;
         if (observed() !== it.v) begin
            failures++;
            $display("FAIL %s: got %s, want %s", it.tag, fmt(observed()), fmt(it.v));
         end
      end
   endtask

   task automatic test_retarget();
      item_t it;
      int    l;
      cs.ti = 2'd2; cs.td = 6'd33;
      for (int k = 1; k <= 8; k++)
         push(ST_ON, 150 + 10 * k, 1, 2, 0, 0, $sformatf("retgt_up_%0d", 150 + 10 * k));
      push(ST_ON, 233, 1, 2, 0, 0, "retgt_up_233");
      push(ST_ON, 233, 1, 2, 0, 0, "retgt_hold_233");
      cs.ti = 2'd0; cs.td = 6'd5;
      l = 233;
      while (l != 5) begin
         l = (l >= 15) ? l - 10 : 5;
         push(ST_ON, l, 1, 2, 0, 0, $sformatf("retgt_dn_%0d", l));
      end
      push(ST_ON, 5, 1, 2, 0, 0, "retgt_hold_5");
      cs.ti = 2'd1; cs.td = 6'd50;
      while (l != 150) begin
         l = (l + 10 > 150) ? 150 : l + 10;
         push(ST_ON, l, 1, 2, 0, 0, $sformatf("retgt_back_%0d", l));
      end
      while (sb.size() > 0) begin
         it = sb.pop_front();
         apply(it.s);
         @(posedge clk); #1;
         checks++;
         if (observed() !== it.v) begin
            failures++;
            $display("FAIL %s: got %s, want %s", it.tag, fmt(observed()), fmt(it.v));
         end
      end
   endtask

   task automatic test_fault();
      item_t it;
      cs.warn = 1'b1;
      push(ST_RETRACT, 150, 1, 1, 1, 0, "fault_enter");
      cs.warn = 1'b0;
      for (int k = 1; k <= 15; k++)
         push((k == 15) ? ST_LOCKOUT : ST_RETRACT, 150 - 10 * k, k < 15, (k < 15) ? 1 : 0, 1, 0,
              $sformatf("fault_retract_%0d", 150 - 10 * k));
      for (int k = 0; k < 3; k++)
         push(ST_LOCKOUT, 0, 0, 0, 1, 0, "lockout_hold");
      cs.on = 1'b0;
      push(ST_OFF, 0, 0, 0, 0, 0, "lockout_release");
      while (sb.size() > 0) begin
         it = sb.pop_front();
         apply(it.s);
         @(posedge clk); #1;
         checks++;
         if (observed() !== it.v) begin
            failures++;
            $display("FAIL %s: got %s, want %s", it.tag, fmt(observed()), fmt(it.v));
         end
      end
   endtask

   task automatic test_denied();
      item_t it;
      cs.lvl = 8'd10; cs.on = 1'b1;
      for (int k = 0; k < 3; k++)
         push(ST_OFF, 0, 0, 0, 0, 1, "denied_low_power");
      cs.lvl = 8'd16;
      push(ST_IGNITE, 0, 1, 1, 0, 0, "denied_then_min_level");
      while (sb.size() > 0) begin
         it = sb.pop_front();
         apply(it.s);
         @(posedge clk); #1;
         checks++;
         if (observed() !== it.v) begin
            failures++;
            $display("FAIL %s: got %s, want %s", it.tag, fmt(observed()), fmt(it.v));
         end
      end
   endtask

   task automatic test_abort();
      item_t it;
      for (int k = 1; k <= 6; k++)
         push(ST_IGNITE, 10 * k, 1, 1, 0, 0, $sformatf("abort_ramp_%0d", 10 * k));
      cs.on = 1'b0;
      push(ST_RETRACT, 60, 1, 1, 0, 0, "abort_enter");
      cs.on = 1'b1;
      for (int k = 1; k <= 6; k++)
         push((k == 6) ? ST_COOLDOWN : ST_RETRACT, 60 - 10 * k, k < 6, (k < 6) ? 1 : 0, 0, 0,
              $sformatf("abort_retract_%0d", 60 - 10 * k));
      for (int k = 2; k <= 8; k++)
         push(ST_COOLDOWN, 0, 0, 0, 0, 0, $sformatf("cooldown_cycle_%0d", k));
      push(ST_OFF, 0, 0, 0, 0, 0, "cooldown_exit");
      push(ST_IGNITE, 0, 1, 1, 0, 0, "reignite");
      while (sb.size() > 0) begin
         it = sb.pop_front();
         apply(it.s);
         @(posedge clk); #1;
         checks++;
         if (observed() !== it.v) begin
            failures++;
            $display("FAIL %s: got %s, want %s", it.tag, fmt(observed()), fmt(it.v));
         end
      end
   endtask

   task automatic test_reset_mid();
      item_t it;
      for (int k = 1; k <= 8; k++)
         push(ST_IGNITE, 10 * k, 1, 1, 0, 0, $sformatf("midreset_ramp_%0d", 10 * k));
      cs.rst = 1'b1;
      push(ST_OFF, 0, 0, 0, 0, 0, "midreset_clear");
      cs.rst = 1'b0; cs.on = 1'b0;
      push(ST_OFF, 0, 0, 0, 0, 0, "midreset_idle");
      while (sb.size() > 0) begin
         it = sb.pop_front();
         apply(it.s);
         @(posedge clk); #1;
         checks++;
         if (observed() !== it.v) begin
            failures++;
            $display("FAIL %s: got %s, want %s", it.tag, fmt(observed()), fmt(it.v));
         end
      end
   endtask

   task automatic test_zero_target();
      item_t it;
      cs.ti = 2'd0; cs.td = 6'd0; cs.us = 2'd3; cs.on = 1'b1;
      push(ST_IGNITE, 0, 1, 1, 0, 0, "zero_ignite");
      push(ST_ON, 0, 1, 3, 0, 0, "zero_on_first_edge");
      push(ST_ON, 0, 1, 3, 0, 0, "zero_on_hold");
      cs.on = 1'b0; cs.warn = 1'b1;
      push(ST_RETRACT, 0, 1, 1, 1, 0, "fault_wins_over_off");
      cs.warn = 1'b0;
      push(ST_LOCKOUT, 0, 0, 0, 1, 0, "zero_retract_done");
      push(ST_OFF, 0, 0, 0, 0, 0, "zero_lockout_release");
      while (sb.size() > 0) begin
         it = sb.pop_front();
         apply(it.s);
         @(posedge clk); #1;
         checks++;
         if (observed() !== it.v) begin
            failures++;
            $display("FAIL %s: got %s, want %s", it.tag, fmt(observed()), fmt(it.v));
         end
      end
   endtask

   initial begin
      bus.on_req      = 1'b0;
      bus.power_warn  = 1'b0;
      bus.power_level = 8'd0;
      bus.tgt_int     = 2'd0;
      bus.tgt_dec     = 6'd0;
      bus.use_sel     = 2'd0;
      test_reset();
      test_ignite();
      test_retarget();
      test_fault();
      test_denied();
      test_abort();
      test_reset_mid();
      test_zero_target();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
